// File: rtl/fb_write_buffer.sv
// Framebuffer write buffer: clips screen points, linearises (x,y) to a word
// address and queues pixels in a show-ahead FIFO drained over valid/ready.
module fb_write_buffer #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned DEPTH    = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ENB,
  input  logic [15:0]       xAddr,
  input  logic [15:0]       yAddr,
  input  logic              Write,
  input  logic [PIX_W-1:0]  PixIn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [PIX_W-1:0]  MemData,
  output logic              MemValid,
  input  logic              MemReady,
  output logic              Overflow,
  output logic [15:0]       ClipCnt,
  input  logic              ClrFlags,
  output logic              Busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned MW = ADDR_W + 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } entry_t;

  entry_t          s1_q;
  logic            s1_valid;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            capture_c;
  logic            clip_c;
  logic [MW-1:0]   lin_addr_c;
  logic            full_c;
  logic            pop_c;
  logic            push_c;
  logic            drop_c;
  logic [PW-1:0]   rd_ptr_next_c;
  logic [CW-1:0]   count_next_c;
  entry_t          head_next_c;

  // Stage-1 clip decision and address linearisation
  always_comb begin
    capture_c  = 1'b0;
    clip_c     = 1'b0;
    lin_addr_c = MW'(yAddr) * MW'(SCREEN_W) + MW'(xAddr);
    if (ENB && Write) begin
      if ((32'(xAddr) < SCREEN_W) && (32'(yAddr) < SCREEN_H)) capture_c = 1'b1;
      else                                                    clip_c    = 1'b1;
    end
  end

  // FIFO control; a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    full_c        = (count == CW'(DEPTH));
    pop_c         = MemValid & MemReady;
    push_c        = s1_valid & (~full_c | pop_c);
    drop_c        = s1_valid & full_c & ~pop_c;
    rd_ptr_next_c = pop_c ? rd_ptr + PW'(1) : rd_ptr;
    count_next_c  = count;
    if (push_c && !pop_c)      count_next_c = count + CW'(1);
    else if (!push_c && pop_c) count_next_c = count - CW'(1);
    // Bypass when the new head is the slot being written this cycle
    head_next_c = '{addr: MemAddr, data: MemData};
    if (count_next_c != '0) begin
      if (push_c && (wr_ptr == rd_ptr_next_c)) head_next_c = s1_q;
      else                                     head_next_c = mem[rd_ptr_next_c];
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_c) mem[wr_ptr] <= s1_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      MemAddr  <= '0;
      MemData  <= '0;
      MemValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      s1_valid <= capture_c;
      if (capture_c) s1_q <= '{addr: ADDR_W'(lin_addr_c), data: PixIn};
      rd_ptr   <= rd_ptr_next_c;
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      count    <= count_next_c;
      MemAddr  <= head_next_c.addr;
      MemData  <= head_next_c.data;
      MemValid <= (count_next_c != '0);
      Busy     <= capture_c | (count_next_c != '0);
    end
  end

  // Sticky flags; a same-cycle event takes priority over the clear
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      Overflow <= 1'b0;
      ClipCnt  <= '0;
    end else begin
      if (drop_c)        Overflow <= 1'b1;
      else if (ClrFlags) Overflow <= 1'b0;
      if (clip_c) begin
        if (ClrFlags)                 ClipCnt <= 16'd1;
        else if (ClipCnt != 16'hFFFF) ClipCnt <= ClipCnt + 16'd1;
      end else if (ClrFlags) begin
        ClipCnt <= '0;
      end
    end
  end

endmodule

// File: doc/fb_write_buffer.md
Name: fb_write_buffer

Overview:
- Downstream stage of the transformation pipeline.
- Consumes the screen coordinates (xAddr, yAddr) and the Write strobe produced by the transformation unit, together with the aligned source pixel value.
- Clips off-screen points, converts (x,y) to a linear framebuffer word address, and buffers requests in a small FIFO.
- Drains the FIFO to the framebuffer memory port over a valid/ready handshake; absorbs bursts because the upstream pipeline has no backpressure.

Parameters:
- SCREEN_W, 640, visible width in pixels; x >= SCREEN_W is clipped.
- SCREEN_H, 480, visible height in pixels; y >= SCREEN_H is clipped.
- ADDR_W, 19, width of the linear framebuffer address; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
- PIX_W, 8, pixel data width.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- ACLK  in  1  system clock, all logic on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- ENB  in  1  input-side enable; when 0, Write is ignored. The drain side always runs.
- xAddr  in  16  screen x from the transformation unit.
- yAddr  in  16  screen y from the transformation unit.
- Write  in  1  coordinate-valid strobe, one pixel per cycle.
- PixIn  in  PIX_W  pixel value aligned with Write.
- MemAddr  out  ADDR_W  linear word address = y*SCREEN_W + x.
- MemData  out  PIX_W  pixel value to store.
- MemValid  out  1  request valid.
- MemReady  in  1  memory accepts the request this cycle.
- Overflow  out  1  sticky: a request was dropped because the FIFO was full.
- ClipCnt  out  16  saturating count of clipped points.
- ClrFlags  in  1  synchronous clear of Overflow and ClipCnt.
- Busy  out  1  high when stage 1 or the FIFO holds data.

Behaviour:
- Reset (ARESETn=0, asynchronous):
  - MemAddr=0, MemData=0, MemValid=0, Overflow=0, ClipCnt=0, Busy=0.
  - FIFO pointers and count = 0; stage-1 valid = 0.
- Stage 1 (capture/clip), at the edge where ENB & Write:
  - If xAddr < SCREEN_W and yAddr < SCREEN_H: register addr = yAddr*SCREEN_W + xAddr (unsigned, computed at ADDR_W+16 bits, truncated to ADDR_W) and PixIn; set s1_valid=1.
  - Otherwise: s1_valid=0 and ClipCnt increments, saturating at 0xFFFF.
  - Otherwise (ENB & Write not true): s1_valid=0.
- Stage 2 (FIFO push): if s1_valid, push {addr,data} on the next edge.
- Pop: occurs on any edge with MemValid & MemReady.
- Push with FIFO full and no pop in the same cycle: entry dropped, Overflow set to 1, FIFO unchanged.
- Push with FIFO full and a pop in the same cycle: accepted, count unchanged.
- Push and pop with FIFO empty: not possible, since MemValid=0 when the FIFO is empty.
- FIFO is show-ahead:
  - MemValid = (count != 0).
  - MemAddr/MemData = head entry, registered.
  - While MemValid=1 and MemReady=0, MemAddr/MemData must remain stable.
- Latency: Write sampled at edge N gives MemValid=1 after edge N+1 (2-cycle latency, empty FIFO). Sustained throughput is 1 pixel/cycle when MemReady=1.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- ClrFlags:
  - Clears Overflow and ClipCnt on the next edge.
  - A clip or overflow event in the same cycle wins: ClipCnt becomes 1, Overflow stays 1.
- Busy = s1_valid | (count != 0).
- Deassertion of ENB mid-stream: no new pushes; already-captured entries drain normally.
- Reset mid-operation: all contents discarded immediately; no spurious MemValid after release.

Test Plan:
- Reset, then ENB=1, Write=1 for one cycle with x=10, y=2, PixIn=0x5A, MemReady=1 -> MemValid=1 exactly 2 edges later with MemAddr=1290, MemData=0x5A, for one cycle.
- x=640, y=0, then x=0, y=480, then x=0xFFFF, y=5, all with Write=1 -> no MemValid; ClipCnt=3. Pulse ClrFlags -> ClipCnt=0.
- MemReady=0, 12 consecutive valid writes (x=0..11, y=0) -> 8 entries held, Overflow=1. Raise MemReady -> addresses 0..7 emerge in order, one per cycle; Busy falls after the last pop.
- FIFO full, MemReady=1, new write x=100, y=1 in the same cycle as a pop -> accepted, Overflow stays 0, address 740 appears after the earlier entries.
- Random MemReady toggling, 200 writes -> MemAddr/MemData never change while MemValid=1 and MemReady=0; output sequence equals the scoreboard of unclipped inputs.
- Assert ARESETn low with 5 entries queued -> MemValid=0 immediately (asynchronous); after release, MemValid stays 0 with no new writes.
